// File: rtl/msg_pkg.sv
// Shared message-frame definitions for the send and receive drivers:
// sync word, header field placement, FSM encoding and length-to-word helper.
package msg_pkg;

  localparam logic [31:0] SYNC_WORD_DEF = 32'hFDF7_EB90;
  localparam int          HDR_W         = 128;

  localparam int SYNC_LSB  = 96;
  localparam int SYNC_W    = 32;
  localparam int FLEN_LSB  = 80;
  localparam int FLEN_W    = 16;
  localparam int TYPE_LSB  = 64;
  localparam int TYPE_W    = 4;
  localparam int CNT_LSB   = 48;
  localparam int CNT_W     = 16;
  localparam int SRC_LSB   = 40;
  localparam int DES_LSB   = 32;
  localparam int DTYPE_LSB = 24;
  localparam int CHAN_LSB  = 16;
  localparam int ID_W      = 8;
  localparam int LEN_LSB   = 0;
  localparam int LEN_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_e;

  // ceil(len/16) as a 12-bit count of 128-bit payload words
  function automatic logic [11:0] words_from_len(input logic [15:0] len);
    return len[15:4] + {11'd0, |len[3:0]};
  endfunction

endpackage

// File: rtl/msg_header_pack.sv
// Combinational packing of message fields into the 128-bit frame header;
// the receiver's unpacker uses the same field offsets in reverse.
module msg_header_pack
  import msg_pkg::*;
#(
  parameter logic [31:0] SYNC_WORD = SYNC_WORD_DEF
) (
  input  logic [15:0]      i_flen,
  input  logic [3:0]       i_ftype,
  input  logic [15:0]      i_cnt,
  input  logic [7:0]       i_src,
  input  logic [7:0]       i_des,
  input  logic [7:0]       i_dtype,
  input  logic [7:0]       i_chan,
  input  logic [15:0]      i_len,
  output logic [HDR_W-1:0] o_hdr
);

  always_comb begin
    o_hdr                        = '0;
    o_hdr[SYNC_LSB  +: SYNC_W]   = SYNC_WORD;
    o_hdr[FLEN_LSB  +: FLEN_W]   = i_flen;
    o_hdr[TYPE_LSB  +: TYPE_W]   = i_ftype;
    o_hdr[CNT_LSB   +: CNT_W]    = i_cnt;
    o_hdr[SRC_LSB   +: ID_W]     = i_src;
    o_hdr[DES_LSB   +: ID_W]     = i_des;
    o_hdr[DTYPE_LSB +: ID_W]     = i_dtype;
    o_hdr[CHAN_LSB  +: ID_W]     = i_chan;
    o_hdr[LEN_LSB   +: LEN_W]    = i_len;
  end

endmodule

// File: rtl/msg_send_driver.sv
// Transmit driver: accepts a message request, writes its header and then
// passes the payload words straight through to the outbound FIFO.
module msg_send_driver
  import msg_pkg::*;
#(
  parameter logic [31:0] SYNC_WORD     = SYNC_WORD_DEF,
  parameter logic [15:0] MAX_LEN_BYTES = 16'd1024,
  parameter logic [15:0] CNT_INIT      = 16'h0000
) (
  input  logic         sys_clk_i,
  input  logic         rst_i,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic [3:0]   req_type_i,
  input  logic [7:0]   req_src_i,
  input  logic [7:0]   req_des_i,
  input  logic [7:0]   req_data_type_i,
  input  logic [7:0]   req_channel_i,
  input  logic [15:0]  req_len_i,
  input  logic         pld_valid_i,
  output logic         pld_ready_o,
  input  logic [127:0] pld_data_i,
  output logic         wr_en_o,
  output logic [127:0] wr_dout_o,
  input  logic         wr_full_i,
  output logic [15:0]  frame_cnt_o,
  output logic         busy_o,
  output logic         err_len_o
);

  state_e             r_state;
  logic [HDR_W-1:0]   r_hdr;
  logic [11:0]        r_rem;
  logic [15:0]        r_cnt;
  logic               r_err;

  logic [11:0]        w_pw;
  logic [15:0]        w_flen;
  logic [HDR_W-1:0]   w_hdr;
  logic               w_wr_en;
  logic [127:0]       w_dout;
  logic               w_pld_rdy;

  assign w_pw   = words_from_len(req_len_i);
  assign w_flen = {4'd0, w_pw} + 16'd1;

  msg_header_pack #(
    .SYNC_WORD (SYNC_WORD)
  ) u_pack (
    .i_flen  (w_flen),
    .i_ftype (req_type_i),
    .i_cnt   (r_cnt),
    .i_src   (req_src_i),
    .i_des   (req_des_i),
    .i_dtype (req_data_type_i),
    .i_chan  (req_channel_i),
    .i_len   (req_len_i),
    .o_hdr   (w_hdr)
  );

  // Write path is combinational so payload passes with zero added latency
  always_comb begin
    w_wr_en   = 1'b0;
    w_dout    = '0;
    w_pld_rdy = 1'b0;
    case (r_state)
      ST_HEADER: begin
        w_wr_en = !wr_full_i;
        w_dout  = w_wr_en ? r_hdr : '0;
      end
      ST_PAYLOAD: begin
        w_pld_rdy = !wr_full_i;
        w_wr_en   = pld_valid_i && !wr_full_i;
        w_dout    = w_wr_en ? pld_data_i : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_hdr   <= '0;
      r_rem   <= '0;
      r_cnt   <= CNT_INIT;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid_i) begin
            if (req_len_i > MAX_LEN_BYTES) begin
              r_err <= 1'b1;
            end else begin
              r_hdr   <= w_hdr;
              r_rem   <= w_pw;
              r_state <= ST_HEADER;
            end
          end
        end
        ST_HEADER: begin
          if (w_wr_en) begin
            r_cnt   <= r_cnt + 16'd1;
            r_state <= (r_rem == 12'd0) ? ST_IDLE : ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (w_wr_en) begin
            r_rem <= r_rem - 12'd1;
            if (r_rem == 12'd1) r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o = (r_state == ST_IDLE);
  assign busy_o      = (r_state != ST_IDLE);
  assign pld_ready_o = w_pld_rdy;
  assign wr_en_o     = w_wr_en;
  assign wr_dout_o   = w_dout;
  assign frame_cnt_o = r_cnt;
  assign err_len_o   = r_err;

endmodule

// File: doc/msg_send_driver.md
Name: msg_send_driver

Overview:
- Transmit-side counterpart of msg_receive_driver.
- Takes a message request (type, src, des, data type, channel, byte length) and a 128-bit payload stream.
- Builds the 128-bit message header, then writes the header followed by the payload words into a downstream FIFO over the same wr_en/dout/full interface the receiver reads.
- Sits between the message-producing logic and the outbound message FIFO.

Parameters:
SYNC_WORD, 32'hFDF7_EB90, header sync field (bits 127:96)
MAX_LEN_BYTES, 16'd1024, largest legal vld_data_len; larger requests are rejected
CNT_INIT, 16'h0000, frame counter value after reset

Ports:
sys_clk_i  in  1  system clock; all logic on rising edge
rst_i  in  1  synchronous reset, active-high
req_valid_i  in  1  message request valid
req_ready_o  out  1  request accepted when valid&ready
req_type_i  in  4  frame_type field
req_src_i  in  8  source ID
req_des_i  in  8  destination ID
req_data_type_i  in  8  data_type field
req_channel_i  in  8  data_channel field
req_len_i  in  16  valid payload length in bytes
pld_valid_i  in  1  payload word valid
pld_ready_o  out  1  payload word consumed when valid&ready
pld_data_i  in  128  payload word, first byte in bits 127:120
wr_en_o  out  1  FIFO write strobe
wr_dout_o  out  128  FIFO write data
wr_full_i  in  1  FIFO full
frame_cnt_o  out  16  current frame counter value
busy_o  out  1  frame in progress
err_len_o  out  1  one-cycle pulse on rejected request

Behaviour:
- Reset (rst_i=1 at a clock edge): state=IDLE, frame counter=CNT_INIT, captured request fields=0, err_len_o=0. wr_en_o, pld_ready_o and busy_o are 0; req_ready_o is 1 in the first cycle after reset. A reset mid-frame abandons the frame; no further words are written. Words already in the FIFO are the consumer's concern.
- Word count: PW = ceil(req_len_i/16), i.e. (len+15)>>4, 12-bit result. frame_len = PW+1 (header included), 16 bits.
- Header layout: {SYNC_WORD[31:0], frame_len[15:0], 12'h000, type[3:0], frame_cnt[15:0], src[7:0], des[7:0], data_type[7:0], channel[7:0], len[15:0]}.
- States: IDLE, HEADER, PAYLOAD.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i with len>MAX_LEN_BYTES: accept the request, pulse err_len_o next cycle, stay in IDLE, counter unchanged.
  - On any other req_valid_i: register all fields, PW and header (frame_cnt = current counter), then go to HEADER.
- HEADER:
  - wr_en_o = !wr_full_i; wr_dout_o = header.
  - On a write, increment the frame counter (modulo 2^16, FFFF->0000).
  - After the write: go to PAYLOAD if PW>0, otherwise IDLE.
  - If wr_full_i is set, hold in HEADER.
- PAYLOAD:
  - pld_ready_o = !wr_full_i.
  - wr_en_o = pld_valid_i & !wr_full_i; wr_dout_o = pld_data_i (pass-through, zero added latency).
  - Remaining-word counter decrements per write; go to IDLE after the last word.
  - Gaps in pld_valid_i are legal.
- wr_en_o, wr_dout_o and pld_ready_o are combinational from registered state and wr_full_i. They must never assert a write while wr_full_i=1.
- wr_dout_o is 0 whenever wr_en_o=0.
- busy_o = (state != IDLE).
- Throughput: header plus PW words in PW+1 cycles when the FIFO is never full; the next request can be accepted the cycle after the last write.
- req_ready_o=0 outside IDLE. Request inputs are ignored while busy.
- Payload words offered while in IDLE or HEADER are not consumed (pld_ready_o=0).
- frame_cnt_o is the registered counter value.

Decomposition:
- Package msg_pkg holds:
  - the SYNC_WORD default and the header field bit offsets/widths, shared with msg_receive_driver;
  - the state encoding (IDLE/HEADER/PAYLOAD);
  - a words_from_len function.
- One sub-module, msg_header_pack: purely combinational packing of the fields into the 128-bit header. The receiver's unpacker is its mirror.

Test Plan:
- Request type=1, src=13, des=00, dtype=01, ch=02, len=0x12, FIFO never full:
  - header FDF7EB90_0003_0001_0000_13000102_0012 written;
  - exactly 2 payload words pass through;
  - frame_cnt_o goes 0->1.
- Second request with len=0x26:
  - header frame_len=0004, frame_cnt=0001;
  - 3 payload words written;
  - payload supplied with gaps of 5 cycles;
  - no extra writes.
- len=0: header only, frame_len=0001, busy_o high for 1 cycle, pld_ready_o never asserted.
- wr_full_i high for 4 cycles during HEADER and again mid-PAYLOAD:
  - no write while full;
  - payload word held and written once full drops;
  - total writes = PW+1.
- len=MAX_LEN_BYTES+1:
  - err_len_o pulses once;
  - no writes;
  - counter unchanged;
  - the next legal request proceeds normally.
- Preload counter to FFFF via CNT_INIT:
  - first header carries FFFF;
  - counter wraps to 0000.
- Assert rst_i after the 1st payload word of a 3-word frame:
  - outputs go idle next cycle;
  - counter=CNT_INIT;
  - the next frame is correct.
